// File: rtl/writeback_arb_pkg.sv
// Shared definitions for the writeback arbiter: the buffered entry type,
// the hard-wired zero register index and the "does this entry write" test.
// Entry fields are sized by WB_RD_W / WB_DATA_W. writeback_arb's RD_W and
// DATA_W default to these and must not exceed them.
package writeback_arb_pkg;

  localparam int WB_RD_W   = 6;
  localparam int WB_DATA_W = 32;

  localparam logic [WB_RD_W-1:0] REG_ZERO = {WB_RD_W{1'b0}};

  typedef struct packed {
    logic                 regwrite;
    logic [WB_RD_W-1:0]   rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // An entry updates the register file only if flagged and not aimed at x0.
  function automatic logic wb_writes(input wb_entry_t e);
    return e.regwrite && (e.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/writeback_arb_fifo.sv
// wb_fifo: one producer's writeback buffer. It is a power-of-two ring with
// an explicit occupancy counter, so "full" is exact and a pop in the same
// cycle never makes room early. With WB_FWD_EN defined, the module also
// reports the youngest buffered entry that writes the queried register.
module wb_fifo
  import writeback_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  output logic                 ready,
  input  wb_entry_t            din,
  input  logic                 pop,
  output logic                 nonempty,
  output wb_entry_t            head
`ifdef WB_FWD_EN
  ,
  input  logic [WB_RD_W-1:0]   fwd_rd,
  output logic                 fwd_hit,
  output logic [WB_DATA_W-1:0] fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  wb_entry_t     mem_r [DEPTH];
  logic          push_s;

  assign ready    = (count_r != CW'(DEPTH));
  assign nonempty = (count_r != CW'(0));
  assign push_s   = push_valid && ready;
  assign head     = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until covered by count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

`ifdef WB_FWD_EN
  // Scan from oldest to youngest so that the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = {WB_DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_r) && (fwd_rd != REG_ZERO) &&
          mem_r[rd_ptr_r + PW'(i)].regwrite &&
          (mem_r[rd_ptr_r + PW'(i)].rd == fwd_rd)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_r[rd_ptr_r + PW'(i)].data;
      end else begin
        fwd_hit  = fwd_hit;
      end
    end
  end
`endif

endmodule

// File: rtl/writeback_arb.sv
// writeback_arb: NCH producer channels, each buffered in a wb_fifo. A
// round-robin arbiter retires one head per cycle into registered regfile
// write outputs. Optional macro WB_FWD_EN adds a combinational forwarding
// lookup (fwd_rd -> fwd_hit/fwd_data) over the buffers and the output stage.
module writeback_arb
  import writeback_arb_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int DEPTH  = 2,
  parameter int DATA_W = WB_DATA_W,
  parameter int RD_W   = WB_RD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  input  logic [NCH-1:0]        in_regwrite,
  input  logic [NCH*RD_W-1:0]   in_rd,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic                  regwrite,
  output logic [RD_W-1:0]       rd,
  output logic [DATA_W-1:0]     regwdata,
  output logic [NCH-1:0]        retire
`ifdef WB_FWD_EN
  ,
  input  logic [RD_W-1:0]       fwd_rd,
  output logic                  fwd_hit,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  wb_entry_t      in_entry [NCH];
  wb_entry_t      heads    [NCH];
  wb_entry_t      head_sel_s;
  logic [NCH-1:0] nonempty;
  logic [NCH-1:0] grant_s;
  logic           grant_found_s;
  logic [GW-1:0]  grant_idx_s;
  logic [GW-1:0]  last_grant_r;

`ifdef WB_FWD_EN
  logic                 ch_hit  [NCH];
  logic [WB_DATA_W-1:0] ch_data [NCH];
`endif

  // Channel index visited at search step 'step' after 'last'.
  function automatic int rr_idx(input int last, input int step, input int n);
    return (last + step) % n;
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign in_entry[c] = '{regwrite: in_regwrite[c],
                           rd:       WB_RD_W'(in_rd[c*RD_W +: RD_W]),
                           data:     WB_DATA_W'(in_data[c*DATA_W +: DATA_W])};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (in_valid[c]),
      .ready      (in_ready[c]),
      .din        (in_entry[c]),
      .pop        (grant_s[c]),
      .nonempty   (nonempty[c]),
      .head       (heads[c])
`ifdef WB_FWD_EN
      ,
      .fwd_rd     (WB_RD_W'(fwd_rd)),
      .fwd_hit    (ch_hit[c]),
      .fwd_data   (ch_data[c])
`endif
    );
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = GW'(0);
    for (int i = 1; i <= NCH; i++) begin
      if (!grant_found_s && nonempty[rr_idx(int'(last_grant_r), i, NCH)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = GW'(rr_idx(int'(last_grant_r), i, NCH));
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    if (grant_found_s) begin
      grant_s = NCH'(1) << grant_idx_s;
    end else begin
      grant_s = NCH'(0);
    end
    head_sel_s = heads[grant_idx_s];
  end

  // Output stage: register the granted head; rd/regwdata hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite     <= 1'b0;
      rd           <= RD_W'(0);
      regwdata     <= DATA_W'(0);
      retire       <= NCH'(0);
      last_grant_r <= GW'(NCH - 1);
    end else if (grant_found_s) begin
      regwrite     <= wb_writes(head_sel_s);
      rd           <= head_sel_s.rd[RD_W-1:0];
      regwdata     <= head_sel_s.data[DATA_W-1:0];
      retire       <= grant_s;
      last_grant_r <= grant_idx_s;
    end else begin
      regwrite     <= 1'b0;
      retire       <= NCH'(0);
    end
  end

`ifdef WB_FWD_EN
  // Lowest priority first so later matches override: output stage, then
  // channels from highest to lowest index.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = DATA_W'(0);
    if (fwd_rd != RD_W'(0)) begin
      if (regwrite && (rd == fwd_rd)) begin
        fwd_hit  = 1'b1;
        fwd_data = regwdata;
      end else begin
        fwd_hit  = 1'b0;
      end
      for (int c = NCH - 1; c >= 0; c--) begin
        if (ch_hit[c]) begin
          fwd_hit  = 1'b1;
          fwd_data = ch_data[c][DATA_W-1:0];
        end else begin
          fwd_hit  = fwd_hit;
        end
      end
    end else begin
      fwd_hit  = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arb.sv
// Directed self-checking bench for writeback_arb (NCH=2, DEPTH=2).
// Inputs change 1 time unit after a rising edge. Outputs are checked at
// that same point, so they reflect the edge just taken.
module tb_writeback_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [1:0]  in_regwrite;
  logic [11:0] in_rd;
  logic [63:0] in_data;
  logic        regwrite;
  logic [5:0]  rd;
  logic [31:0] regwdata;
  logic [1:0]  retire;
`ifdef WB_FWD_EN
  logic [5:0]  fwd_rd;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int k0;
  int k1;
  logic a0;
  logic a1;

  writeback_arb #(.NCH(2), .DEPTH(2), .DATA_W(32), .RD_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_regwrite (in_regwrite),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .regwrite    (regwrite),
    .rd          (rd),
    .regwdata    (regwdata),
    .retire      (retire)
`ifdef WB_FWD_EN
    ,
    .fwd_rd      (fwd_rd),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int c, input logic v, input logic w,
                     input logic [5:0] r, input logic [31:0] d);
    in_valid[c]        = v;
    in_regwrite[c]     = w;
    in_rd[c*6 +: 6]    = r;
    in_data[c*32 +: 32] = d;
  endtask

  function automatic logic [5:0] exp_rd(input int ch, input int k);
    return 6'(1 + ch * 8 + k);
  endfunction

  function automatic logic [31:0] exp_data(input int ch, input int k);
    return 32'hA000_0000 | (32'(ch) << 16) | 32'(k);
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 2'b00;
    in_regwrite = 2'b00;
    in_rd = 12'h000;
    in_data = 64'h0;
`ifdef WB_FWD_EN
    fwd_rd = 6'd0;
`endif

    // Reset state
    step();
    step();
    chk("rst_regwrite", 64'(regwrite), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_regwdata", 64'(regwdata), 64'd0);
    chk("rst_retire", 64'(retire), 64'd0);
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd3);

    // Single push on ch0: visible after the second edge, then idle
    put(0, 1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF);
    step();
    put(0, 1'b0, 1'b0, 6'd0, 32'h0);
    chk("single_lat_regwrite", 64'(regwrite), 64'd0);
    chk("single_lat_retire", 64'(retire), 64'd0);
    step();
    chk("single_regwrite", 64'(regwrite), 64'd1);
    chk("single_rd", 64'(rd), 64'd5);
    chk("single_data", 64'(regwdata), 64'hDEAD_BEEF);
    chk("single_retire", 64'(retire), 64'd1);
    step();
    chk("single_idle_regwrite", 64'(regwrite), 64'd0);
    chk("single_idle_retire", 64'(retire), 64'd0);
    chk("single_hold_rd", 64'(rd), 64'd5);
    chk("single_hold_data", 64'(regwdata), 64'hDEAD_BEEF);

    // Reset restores last_grant to ch1 so the next stream starts on ch0
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Both channels stream 8 entries each, producers honour in_ready
    k0 = 0;
    k1 = 0;
    put(0, 1'b1, 1'b1, exp_rd(0, 0), exp_data(0, 0));
    put(1, 1'b1, 1'b1, exp_rd(1, 0), exp_data(1, 0));
    for (int e = 1; e <= 17; e++) begin
      a0 = in_valid[0] & in_ready[0];
      a1 = in_valid[1] & in_ready[1];
      step();
      if (a0) k0++;
      if (a1) k1++;
      put(0, k0 < 8, 1'b1, exp_rd(0, k0), exp_data(0, k0));
      put(1, k1 < 8, 1'b1, exp_rd(1, k1), exp_data(1, k1));
      if (e >= 2) begin
        chk("rr_retire", 64'(retire), ((e - 2) % 2 == 1) ? 64'd2 : 64'd1);
        chk("rr_regwrite", 64'(regwrite), 64'd1);
        chk("rr_rd", 64'(rd), 64'(exp_rd((e - 2) % 2, (e - 2) / 2)));
        chk("rr_data", 64'(regwdata), 64'(exp_data((e - 2) % 2, (e - 2) / 2)));
      end
    end
    step();
    chk("rr_idle_retire", 64'(retire), 64'd0);
    chk("rr_idle_regwrite", 64'(regwrite), 64'd0);

    // ch1 fills while ch0 streams; a push to full ch1 is dropped
    put(0, 1'b1, 1'b1, 6'd20, 32'h0A00_0000);
    put(1, 1'b1, 1'b1, 6'd30, 32'h0B00_0000);
    step();
    chk("full_e1_retire", 64'(retire), 64'd0);
    put(0, 1'b1, 1'b1, 6'd21, 32'h0A00_0001);
    put(1, 1'b1, 1'b1, 6'd31, 32'h0B00_0001);
    step();
    chk("full_e2_retire", 64'(retire), 64'd1);
    chk("full_e2_data", 64'(regwdata), 64'h0A00_0000);
    chk("full_ch1_not_ready", 64'(in_ready[1]), 64'd0);
    put(0, 1'b1, 1'b1, 6'd22, 32'h0A00_0002);
    put(1, 1'b1, 1'b1, 6'd33, 32'h0BAD_0000);
    step();
    put(0, 1'b0, 1'b0, 6'd0, 32'h0);
    put(1, 1'b0, 1'b0, 6'd0, 32'h0);
    chk("full_e3_retire", 64'(retire), 64'd2);
    chk("full_e3_data", 64'(regwdata), 64'h0B00_0000);
    chk("full_e3_ready", 64'(in_ready), 64'd2);
    step();
    chk("full_e4_retire", 64'(retire), 64'd1);
    chk("full_e4_data", 64'(regwdata), 64'h0A00_0001);
    step();
    chk("full_e5_retire", 64'(retire), 64'd2);
    chk("full_e5_rd", 64'(rd), 64'd31);
    chk("full_e5_data", 64'(regwdata), 64'h0B00_0001);
    step();
    chk("full_e6_retire", 64'(retire), 64'd1);
    chk("full_e6_data", 64'(regwdata), 64'h0A00_0002);
    step();
    chk("full_drained_retire", 64'(retire), 64'd0);
    chk("full_drained_regwrite", 64'(regwrite), 64'd0);

    // rd=0 on ch1 and regwrite flag clear on ch0 both retire without a write
    put(0, 1'b1, 1'b0, 6'd9, 32'h0000_0066);
    put(1, 1'b1, 1'b1, 6'd0, 32'h0000_0055);
    step();
    put(0, 1'b0, 1'b0, 6'd0, 32'h0);
    put(1, 1'b0, 1'b0, 6'd0, 32'h0);
    chk("nowr_e1_retire", 64'(retire), 64'd0);
    step();
    chk("rd0_retire", 64'(retire), 64'd2);
    chk("rd0_regwrite", 64'(regwrite), 64'd0);
    chk("rd0_data", 64'(regwdata), 64'h55);
    step();
    chk("wr0_retire", 64'(retire), 64'd1);
    chk("wr0_regwrite", 64'(regwrite), 64'd0);
    chk("wr0_rd", 64'(rd), 64'd9);
    chk("wr0_data", 64'(regwdata), 64'h66);
    step();
    chk("nowr_idle_retire", 64'(retire), 64'd0);
    chk("nowr_hold_rd", 64'(rd), 64'd9);

    // Reset with three entries buffered discards them
    put(0, 1'b1, 1'b1, 6'd3, 32'h0000_0300);
    put(1, 1'b1, 1'b1, 6'd4, 32'h0000_0400);
    step();
    put(0, 1'b1, 1'b1, 6'd3, 32'h0000_0301);
    put(1, 1'b1, 1'b1, 6'd4, 32'h0000_0401);
    step();
    put(0, 1'b0, 1'b0, 6'd0, 32'h0);
    put(1, 1'b0, 1'b0, 6'd0, 32'h0);
    chk("pre_rst_retire", 64'(retire), 64'd2);
    chk("pre_rst_rd", 64'(rd), 64'd4);
    chk("pre_rst_ready", 64'(in_ready), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_regwrite", 64'(regwrite), 64'd0);
    chk("mid_rst_rd", 64'(rd), 64'd0);
    chk("mid_rst_data", 64'(regwdata), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_regwrite", 64'(regwrite), 64'd0);
      chk("post_rst_retire", 64'(retire), 64'd0);
      chk("post_rst_ready", 64'(in_ready), 64'd3);
    end

`ifdef WB_FWD_EN
    // Forwarding from a buffered entry, then from the output register
    put(1, 1'b1, 1'b1, 6'd7, 32'h0000_1234);
    fwd_rd = 6'd7;
    step();
    put(1, 1'b0, 1'b0, 6'd0, 32'h0);
    chk("fwd_buf_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_buf_data", 64'(fwd_data), 64'h1234);
    fwd_rd = 6'd0;
    #1;
    chk("fwd_rd0_hit", 64'(fwd_hit), 64'd0);
    fwd_rd = 6'd7;
    step();
    chk("fwd_out_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_out_data", 64'(fwd_data), 64'h1234);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_arb.md
WRITEBACK_ARB -- requirements
Module: writeback_arb

Interface
REQ-001 The module SHALL have parameter NCH, default 2, giving the number of producer channels (1..8).
REQ-002 The module SHALL have parameter DEPTH, default 2, giving per-channel buffer entries (power of two, >=2).
REQ-003 The module SHALL have parameter DATA_W, default 32, giving the writeback data width.
REQ-004 The module SHALL have parameter RD_W, default 6, giving the destination register index width.
REQ-005 The module SHALL have port clk, input, 1: the single clock.
REQ-006 The module SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 The module SHALL have port in_valid, input, NCH: per-channel result valid.
REQ-008 The module SHALL have port in_ready, output, NCH: per-channel buffer not full.
REQ-009 The module SHALL have port in_regwrite, input, NCH: per-channel write-enable flag.
REQ-010 The module SHALL have port in_rd, input, NCH*RD_W: per-channel destination index.
REQ-011 The module SHALL have port in_data, input, NCH*DATA_W: per-channel result data.
REQ-012 The module SHALL have port regwrite, output, 1: register file write strobe.
REQ-013 The module SHALL have port rd, output, RD_W: register file write index.
REQ-014 The module SHALL have port regwdata, output, DATA_W: register file write data.
REQ-015 The module SHALL have port retire, output, NCH: one-hot pulse naming the channel whose entry left its buffer this cycle.

Function
REQ-016 Channel c SHALL accept an entry at a rising clk edge iff in_valid[c] and in_ready[c] are both high.
REQ-017 in_ready[c] SHALL be high iff buffer c holds fewer than DEPTH entries; a same-cycle pop SHALL NOT raise it.
REQ-018 Each buffer SHALL be FIFO; pointers SHALL wrap modulo DEPTH; occupancy SHALL be held in a counter 0..DEPTH.
REQ-019 Each cycle, a round-robin arbiter SHALL grant exactly one non-empty buffer head, searching from last_grant+1 upward, wrapping at NCH.
REQ-020 last_grant SHALL update only on a grant; with no non-empty buffer, no grant SHALL occur.
REQ-021 On a grant, the head SHALL be popped and regwrite/rd/regwdata registered at that same edge; retire SHALL be a registered pulse aligned with them.
REQ-022 Latency: an entry accepted at edge t on an idle arbiter SHALL appear on regwrite/rd/regwdata in the cycle following edge t+1.
REQ-023 A granted entry with in_regwrite=0 or rd=0 SHALL retire with regwrite=0 (rd, regwdata still driven).
REQ-024 With no grant, regwrite SHALL be 0 and retire all zero; rd and regwdata SHALL hold their previous values.
REQ-025 Simultaneous push and pop on one buffer SHALL keep occupancy unchanged and preserve order.
REQ-026 Sustained throughput SHALL be one retirement per cycle when any buffer is non-empty.

Reset
REQ-027 While rst is high at an edge, all buffers SHALL empty, last_grant SHALL become NCH-1, regwrite=0, rd=0, regwdata=0, retire=0.
REQ-028 Reset mid-operation SHALL discard all buffered entries without emitting writes; in_ready SHALL be all ones in the cycle after reset deasserts.

Configuration
REQ-029 With macro WB_FWD_EN defined, the module SHALL add inputs fwd_rd (RD_W) and outputs fwd_hit (1), fwd_data (DATA_W), combinationally reporting a buffered or output-stage entry with regwrite=1 and matching nonzero rd.
REQ-030 Under WB_FWD_EN, priority SHALL be: youngest entry of lowest channel index, then output register; fwd_rd=0 SHALL give fwd_hit=0.
REQ-031 Without WB_FWD_EN, these ports SHALL not exist and behaviour SHALL otherwise be identical.

Structure
REQ-032 Typedef wb_entry_t {regwrite, rd, data} and constant REG_ZERO=0 SHALL live in the shared def package.
REQ-033 Per-channel buffering SHALL be a sub-module wb_fifo instantiated NCH times; arbitration and output registers SHALL stay in writeback_arb.

Verification
REQ-034 Single push ch0 {1, rd=5, 0xDEADBEEF} at edge 1 -> regwrite=1, rd=5, regwdata=0xDEADBEEF, retire=01 after edge 2, idle after.
REQ-035 Both channels push every cycle for 8 cycles, NCH=2 -> retire alternates 01,10,... starting 01; all 16 entries retire in per-channel order.
REQ-036 Fill ch1 with DEPTH entries while arbiter stalled by stream on ch0 -> in_ready[1]=0; push attempt ignored; occupancy stays DEPTH.
REQ-037 Entry with rd=0 or in_regwrite=0 -> retire pulse occurs, regwrite=0.
REQ-038 rst asserted with 3 entries buffered -> no regwrite afterwards; in_ready all ones after deassert.
REQ-039 WB_FWD_EN: buffer {1, rd=7, 0x1234} in ch1, fwd_rd=7 -> fwd_hit=1, fwd_data=0x1234; fwd_rd=0 -> fwd_hit=0.
